// File: rtl/magic_core_pkg.sv
// Shared types for the magic_core AXI4-Lite register file.
// Response codes, per-register modes and the read/write channel state encodings.
// Combinational helpers only; no latency and no flow control in this file.
package magic_core_pkg;

    localparam int unsigned MAX_REGS = 64;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } axi_resp_t;

    typedef enum logic [1:0] {
        MODE_RW  = 2'd0,
        MODE_RO  = 2'd1,
        MODE_W1C = 2'd2
    } reg_mode_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    // RO takes precedence; overlapping masks are rejected at elaboration by the top.
    function automatic reg_mode_t reg_mode(input logic [5:0]          idx,
                                           input logic [MAX_REGS-1:0] ro_mask,
                                           input logic [MAX_REGS-1:0] w1c_mask);
        if (ro_mask[idx]) begin
            return MODE_RO;
        end
        if (w1c_mask[idx]) begin
            return MODE_W1C;
        end
        return MODE_RW;
    endfunction

endpackage

// File: rtl/magic_core_axil_wr_ctrl.sv
// AXI4-Lite write channel: independent AW/W capture, commit strobe, B response FSM.
// Latency: commit in the first cycle both AW and W are held; BVALID on the following edge.
// Backpressure: AWREADY/WREADY drop while their beat is held or B is outstanding.
module magic_core_axil_wr_ctrl
    import magic_core_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned IDX_W      = $clog2(NUM_REGS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     awaddr,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    output logic                      wr_en,
    output logic                      wr_err,
    output logic [IDX_W-1:0]          wr_idx,
    output logic [DATA_WIDTH-1:0]     wr_dat,
    output logic [DATA_WIDTH/8-1:0]   wr_strb
);

    localparam int unsigned          ADDR_LSB = $clog2(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH:0]  ADDR_END = (ADDR_WIDTH + 1)'(NUM_REGS * DATA_WIDTH / 8);

    w_state_t                  state_q,   state_d;
    logic                      aw_held_q, aw_held_d;
    logic                      w_held_q,  w_held_d;
    logic [ADDR_WIDTH-1:0]     awaddr_q,  awaddr_d;
    logic [DATA_WIDTH-1:0]     wdata_q,   wdata_d;
    logic [DATA_WIDTH/8-1:0]   wstrb_q,   wstrb_d;
    axi_resp_t                 bresp_q,   bresp_d;

    // Readies are forced low while reset is asserted so nothing is accepted mid-reset.
    assign awready = (state_q == W_IDLE) && !aw_held_q && !rst;
    assign wready  = (state_q == W_IDLE) && !w_held_q  && !rst;
    assign bvalid  = (state_q == W_RESP);
    assign bresp   = bresp_q;

    assign wr_en   = (state_q == W_IDLE) && aw_held_q && w_held_q;
    assign wr_err  = {1'b0, awaddr_q} >= ADDR_END;
    assign wr_idx  = awaddr_q[ADDR_LSB +: IDX_W];
    assign wr_dat  = wdata_q;
    assign wr_strb = wstrb_q;

    always_comb begin
        state_d   = state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;

        if (awvalid && awready) begin
            aw_held_d = 1'b1;
            awaddr_d  = awaddr;
        end
        if (wvalid && wready) begin
            w_held_d = 1'b1;
            wdata_d  = wdata;
            wstrb_d  = wstrb;
        end

        case (state_q)
            W_IDLE: begin
                if (wr_en) begin
                    state_d   = W_RESP;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    bresp_d   = wr_err ? RESP_SLVERR : RESP_OKAY;
                end
            end
            W_RESP: begin
                if (bready) begin
                    state_d = W_IDLE;
                    bresp_d = RESP_OKAY;
                end
            end
            default: state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
        end
    end

endmodule

// File: rtl/magic_core_regfile.sv
// Parametrised AXI4-Lite register file with RW, RO (hw status) and W1C (sticky event) registers.
// Latency: write lands one edge after AW+W are both held; RDATA one cycle after AR; irq_o one after.
// Backpressure: one outstanding write and one outstanding read; readies low until B/R is taken.
module magic_core_regfile
    import magic_core_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter logic [63:0] RO_MASK    = 64'h0,
    parameter logic [63:0] W1C_MASK   = 64'h0
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                     S_AXI_AWPROT,
    input  logic                           S_AXI_AWVALID,
    output logic                           S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                           S_AXI_WVALID,
    output logic                           S_AXI_WREADY,
    output logic [1:0]                     S_AXI_BRESP,
    output logic                           S_AXI_BVALID,
    input  logic                           S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                     S_AXI_ARPROT,
    input  logic                           S_AXI_ARVALID,
    output logic                           S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                     S_AXI_RRESP,
    output logic                           S_AXI_RVALID,
    input  logic                           S_AXI_RREADY,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status_i,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_event_i,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q_o,
    output logic                           irq_o
);

    localparam int unsigned         STRB_W   = DATA_WIDTH / 8;
    localparam int unsigned         IDX_W    = $clog2(NUM_REGS);
    localparam int unsigned         ADDR_LSB = $clog2(STRB_W);
    localparam logic [ADDR_WIDTH:0] ADDR_END = (ADDR_WIDTH + 1)'(NUM_REGS * STRB_W);

    if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_data_width
        $error("magic_core_regfile: DATA_WIDTH must be 32 or 64");
    end
    if (NUM_REGS < 2 || NUM_REGS > 64 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_bad_num_regs
        $error("magic_core_regfile: NUM_REGS must be a power of two in 2..64");
    end
    if (ADDR_WIDTH < $clog2(NUM_REGS * STRB_W)) begin : g_bad_addr_width
        $error("magic_core_regfile: ADDR_WIDTH too small for the register window");
    end
    if ((RO_MASK & W1C_MASK) != 64'h0) begin : g_bad_masks
        $error("magic_core_regfile: RO_MASK and W1C_MASK overlap");
    end

    logic                     wr_en;
    logic                     wr_err;
    logic                     commit;
    logic [IDX_W-1:0]         wr_idx;
    logic [DATA_WIDTH-1:0]    wr_dat;
    logic [STRB_W-1:0]        wr_strb;
    logic [DATA_WIDTH-1:0]    strb_mask;

    magic_core_axil_wr_ctrl #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .IDX_W      (IDX_W)
    ) u_wr_ctrl (
        .clk     (ACLK),
        .rst     (ARESET),
        .awaddr  (S_AXI_AWADDR),
        .awvalid (S_AXI_AWVALID),
        .awready (S_AXI_AWREADY),
        .wdata   (S_AXI_WDATA),
        .wstrb   (S_AXI_WSTRB),
        .wvalid  (S_AXI_WVALID),
        .wready  (S_AXI_WREADY),
        .bresp   (S_AXI_BRESP),
        .bvalid  (S_AXI_BVALID),
        .bready  (S_AXI_BREADY),
        .wr_en   (wr_en),
        .wr_err  (wr_err),
        .wr_idx  (wr_idx),
        .wr_dat  (wr_dat),
        .wr_strb (wr_strb)
    );

    // Out-of-range writes still complete on B (SLVERR) but must not touch any register.
    assign commit = wr_en && !wr_err;

    for (genvar k = 0; k < STRB_W; k++) begin : g_strb
        assign strb_mask[k*8 +: 8] = {8{wr_strb[k]}};
    end

    logic [DATA_WIDTH-1:0] reg_val [NUM_REGS];
    logic [NUM_REGS-1:0]   w1c_any;

    for (genvar n = 0; n < NUM_REGS; n++) begin : g_reg
        localparam reg_mode_t MODE = reg_mode(6'(n), RO_MASK, W1C_MASK);

        if (MODE == MODE_RO) begin : g_ro
            assign reg_val[n] = hw_status_i[n*DATA_WIDTH +: DATA_WIDTH];
            assign w1c_any[n] = 1'b0;
        end else begin : g_store
            logic                  wr_hit;
            logic [DATA_WIDTH-1:0] val_d, val_q;

            assign wr_hit = commit && (wr_idx == IDX_W'(n));

            // For W1C the event OR is applied after the clear, so a same-cycle set wins.
            always_comb begin
                val_d = val_q;
                if (MODE == MODE_W1C) begin
                    val_d = (val_q & ~(wr_hit ? (wr_dat & strb_mask) : '0))
                          | hw_event_i[n*DATA_WIDTH +: DATA_WIDTH];
                end else if (wr_hit) begin
                    val_d = (val_q & ~strb_mask) | (wr_dat & strb_mask);
                end
            end

            always_ff @(posedge ACLK or posedge ARESET) begin
                if (ARESET) begin
                    val_q <= '0;
                end else begin
                    val_q <= val_d;
                end
            end

            assign reg_val[n] = val_q;
            assign w1c_any[n] = (MODE == MODE_W1C) ? |val_q : 1'b0;
        end

        assign reg_q_o[n*DATA_WIDTH +: DATA_WIDTH] = reg_val[n];
    end

    logic irq_q, irq_d;

    assign irq_d = |w1c_any;
    assign irq_o = irq_q;

    r_state_t              rstate_q, rstate_d;
    logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;
    axi_resp_t             rresp_q,  rresp_d;
    logic [IDX_W-1:0]      rd_idx;
    logic                  rd_err;

    assign rd_idx        = S_AXI_ARADDR[ADDR_LSB +: IDX_W];
    assign rd_err        = {1'b0, S_AXI_ARADDR} >= ADDR_END;
    assign S_AXI_ARREADY = (rstate_q == R_IDLE) && !ARESET;
    assign S_AXI_RVALID  = (rstate_q == R_DATA);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

    // reg_val holds current flop outputs, so a read racing a write sees the pre-write value.
    always_comb begin
        rstate_d = rstate_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        case (rstate_q)
            R_IDLE: begin
                if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                    rstate_d = R_DATA;
                    rresp_d  = rd_err ? RESP_SLVERR : RESP_OKAY;
                    rdata_d  = rd_err ? '0 : reg_val[rd_idx];
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    rstate_d = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rstate_q <= R_IDLE;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
            irq_q    <= 1'b0;
        end else begin
            rstate_q <= rstate_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            irq_q    <= irq_d;
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, hw_status_i, hw_event_i};

endmodule

// File: tb/tb_magic_core_regfile.sv
// Directed bench for magic_core_regfile: a default-mask instance and one with RO reg1 / W1C reg2,
// driven from shared AXI stimulus; B/R expectations queued at issue and checked on response.
module tb_magic_core_regfile;

    localparam int          TMO     = 20;
    localparam logic [1:0]  OKAY    = 2'b00;
    localparam logic [1:0]  SLVERR  = 2'b10;

    logic         ACLK = 1'b0;
    logic         ARESET;
    logic [5:0]   awaddr, araddr;
    logic         awvalid, wvalid, bready, arvalid, rready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic [255:0] hw_status, hw_event;
    logic         sel;

    logic         a_awready, a_wready, a_bvalid, a_arready, a_rvalid, a_irq;
    logic [1:0]   a_bresp, a_rresp;
    logic [31:0]  a_rdata;
    logic [255:0] a_reg_q;
    logic         b_awready, b_wready, b_bvalid, b_arready, b_rvalid, b_irq;
    logic [1:0]   b_bresp, b_rresp;
    logic [31:0]  b_rdata;
    logic [255:0] b_reg_q;

    logic         awready, wready, bvalid, arready, rvalid, irq;
    logic [1:0]   bresp, rresp;
    logic [31:0]  rdata;
    logic [255:0] reg_q;

    int n_assert = 0;
    int n_fail   = 0;
    logic [1:0]  bq[$];
    logic [33:0] rq[$];

    always #5 ACLK = ~ACLK;

    magic_core_regfile #(
        .DATA_WIDTH (32), .NUM_REGS (8), .ADDR_WIDTH (6),
        .RO_MASK (64'h0), .W1C_MASK (64'h0)
    ) dut_a (
        .ACLK (ACLK), .ARESET (ARESET),
        .S_AXI_AWADDR (awaddr), .S_AXI_AWPROT (3'b000), .S_AXI_AWVALID (awvalid), .S_AXI_AWREADY (a_awready),
        .S_AXI_WDATA (wdata), .S_AXI_WSTRB (wstrb), .S_AXI_WVALID (wvalid), .S_AXI_WREADY (a_wready),
        .S_AXI_BRESP (a_bresp), .S_AXI_BVALID (a_bvalid), .S_AXI_BREADY (bready),
        .S_AXI_ARADDR (araddr), .S_AXI_ARPROT (3'b000), .S_AXI_ARVALID (arvalid), .S_AXI_ARREADY (a_arready),
        .S_AXI_RDATA (a_rdata), .S_AXI_RRESP (a_rresp), .S_AXI_RVALID (a_rvalid), .S_AXI_RREADY (rready),
        .hw_status_i (hw_status), .hw_event_i (hw_event), .reg_q_o (a_reg_q), .irq_o (a_irq)
    );

    magic_core_regfile #(
        .DATA_WIDTH (32), .NUM_REGS (8), .ADDR_WIDTH (6),
        .RO_MASK (64'h2), .W1C_MASK (64'h4)
    ) dut_b (
        .ACLK (ACLK), .ARESET (ARESET),
        .S_AXI_AWADDR (awaddr), .S_AXI_AWPROT (3'b000), .S_AXI_AWVALID (awvalid), .S_AXI_AWREADY (b_awready),
        .S_AXI_WDATA (wdata), .S_AXI_WSTRB (wstrb), .S_AXI_WVALID (wvalid), .S_AXI_WREADY (b_wready),
        .S_AXI_BRESP (b_bresp), .S_AXI_BVALID (b_bvalid), .S_AXI_BREADY (bready),
        .S_AXI_ARADDR (araddr), .S_AXI_ARPROT (3'b000), .S_AXI_ARVALID (arvalid), .S_AXI_ARREADY (b_arready),
        .S_AXI_RDATA (b_rdata), .S_AXI_RRESP (b_rresp), .S_AXI_RVALID (b_rvalid), .S_AXI_RREADY (rready),
        .hw_status_i (hw_status), .hw_event_i (hw_event), .reg_q_o (b_reg_q), .irq_o (b_irq)
    );

    assign awready = sel ? b_awready : a_awready;
    assign wready  = sel ? b_wready  : a_wready;
    assign bvalid  = sel ? b_bvalid  : a_bvalid;
    assign bresp   = sel ? b_bresp   : a_bresp;
    assign arready = sel ? b_arready : a_arready;
    assign rvalid  = sel ? b_rvalid  : a_rvalid;
    assign rdata   = sel ? b_rdata   : a_rdata;
    assign rresp   = sel ? b_rresp   : a_rresp;
    assign irq     = sel ? b_irq     : a_irq;
    assign reg_q   = sel ? b_reg_q   : a_reg_q;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] exp, input logic [255:0] ev = '0);
        int   cnt;
        logic aw_hs, w_hs;
        logic [1:0] e;
        bq.push_back(exp);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        cnt = 0;
        while ((awvalid || wvalid) && cnt < TMO) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick();
            cnt++;
            if (aw_hs) awvalid = 1'b0;
            if (w_hs)  wvalid  = 1'b0;
        end
        check("aw_w_timeout", cnt < TMO, 1);
        hw_event = ev;            // present during the commit cycle
        tick();
        hw_event = '0;
        cnt = 0;
        while (!bvalid && cnt < TMO) begin
            tick();
            cnt++;
        end
        check("b_timeout", cnt < TMO, 1);
        e = (bq.size() > 0) ? bq.pop_front() : 2'bxx;
        check("bresp", bresp, e);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("b_drop", bvalid, 0);
    endtask

    task automatic axi_read(input logic [5:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r);
        int   cnt;
        logic hs;
        logic [33:0] e;
        rq.push_back({exp_r, exp_d});
        araddr = a; arvalid = 1'b1; rready = 1'b0;
        cnt = 0;
        while (arvalid && cnt < TMO) begin
            hs = arready;
            tick();
            cnt++;
            if (hs) arvalid = 1'b0;
        end
        check("ar_timeout", cnt < TMO, 1);
        cnt = 0;
        while (!rvalid && cnt < TMO) begin
            tick();
            cnt++;
        end
        check("r_timeout", cnt < TMO, 1);
        e = (rq.size() > 0) ? rq.pop_front() : 34'bx;
        check("rdata", rdata, e[31:0]);
        check("rresp", rresp, e[33:32]);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("r_drop", rvalid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 1'b0; ARESET = 1'b1;
        awaddr = '0; araddr = '0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arvalid = 1'b0; rready = 1'b0; wdata = '0; wstrb = '0;
        hw_status = '0; hw_event = '0;

        // Reset state
        repeat (3) tick();
        check("rst_awready", awready, 0);
        check("rst_wready",  wready,  0);
        check("rst_arready", arready, 0);
        check("rst_bvalid",  bvalid,  0);
        check("rst_rvalid",  rvalid,  0);
        check("rst_bresp",   bresp,   0);
        check("rst_rresp",   rresp,   0);
        check("rst_rdata",   rdata,   0);
        check("rst_irq_b",   b_irq,   0);
        check("rst_regs",    a_reg_q, 0);
        ARESET = 1'b0;
        tick();
        check("post_rst_awready", awready, 1);

        // Legacy 4-register write/readback
        for (int i = 0; i < 4; i++) axi_write(6'(i * 4), 32'(i + 1), 4'hF, OKAY);
        for (int i = 0; i < 4; i++) axi_read(6'(i * 4), 32'(i + 1), OKAY);

        // Byte strobes
        axi_write(6'h00, 32'h0, 4'hF, OKAY);
        axi_write(6'h00, 32'hFFFF_FFFF, 4'b0011, OKAY);
        axi_read(6'h00, 32'h0000_FFFF, OKAY);

        // Out of range: SLVERR, no state change, RDATA 0
        axi_write(6'h20, 32'hDEAD_BEEF, 4'hF, SLVERR);
        check("slverr_no_change", a_reg_q, {128'h0, 32'h4, 32'h3, 32'h2, 32'h0000_FFFF});
        axi_read(6'h20, 32'h0, SLVERR);

        // W before AW by 3 cycles, BREADY held low 5 cycles
        bq.push_back(OKAY);
        awaddr = 6'h0C; wdata = 32'hA5A5_A5A5; wstrb = 4'hF; wvalid = 1'b1;
        check("wfirst_wready", wready, 1);
        tick();
        wvalid = 1'b0;
        check("wfirst_wheld", wready, 0);
        check("wfirst_awready", awready, 1);
        tick();
        tick();
        check("wfirst_no_b", bvalid, 0);
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("wfirst_aw_held", awready, 0);
        tick();
        for (int k = 0; k < 5; k++) begin
            check("bstall_bvalid",  bvalid,  1);
            check("bstall_awready", awready, 0);
            check("bstall_wready",  wready,  0);
            tick();
        end
        check("bstall_bresp", bresp, (bq.size() > 0) ? bq.pop_front() : 2'bxx);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("single_b", bvalid, 0);
            tick();
        end
        axi_read(6'h0C, 32'hA5A5_A5A5, OKAY);

        // RO register on the masked instance
        sel = 1'b1;
        hw_status[63:32] = 32'h0000_CAFE;
        axi_write(6'h04, 32'h0000_1234, 4'hF, OKAY);
        axi_read(6'h04, 32'h0000_CAFE, OKAY);

        // W1C: event sets, irq one cycle later, set beats clear, plain clear drops irq
        hw_event[64] = 1'b1;
        tick();
        hw_event = '0;
        check("irq_lag", irq, 0);
        tick();
        check("irq_set", irq, 1);
        axi_write(6'h08, 32'h1, 4'hF, OKAY, 256'h1 << 64);
        axi_read(6'h08, 32'h1, OKAY);
        check("irq_hold", irq, 1);
        axi_write(6'h08, 32'h1, 4'hF, OKAY);
        check("irq_clear", irq, 0);
        axi_read(6'h08, 32'h0, OKAY);

        // Reset while B is outstanding
        sel = 1'b0;
        awaddr = 6'h04; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        check("pre_rst_bvalid", bvalid, 1);
        ARESET = 1'b1;
        #1;
        check("rst_bvalid_async", bvalid, 0);
        check("rst_regs_async", a_reg_q, 0);
        tick();
        ARESET = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) axi_read(6'(i * 4), 32'h0, OKAY);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
